real_corr_acc: RTL and testbench
================================

Name: real_corr_acc

Overview:
- Consumes the centrosymmetric-transformed pair y1, y2 and integrates the real-valued 2x2 correlation matrix R = Re{y y^H} over a runtime-selectable window.
- Emits the three unique entries r11, r22 and r12 (r21 = r12) once per window with a one-cycle valid pulse.
- Sits directly downstream of the centrosym transform and feeds the eigen/DoA angle stage.
- Full-precision arithmetic: no rounding, no saturation.

Parameters:
- DIN_WIDTH, 19, width of each signed y component; equals transform input width + 1.
- ACC_LEN_WIDTH, 10, width of acc_len; maximum window is 2^ACC_LEN_WIDTH - 1 samples.
- DOUT_WIDTH, 2*DIN_WIDTH+1+ACC_LEN_WIDTH (49), accumulator/output width; a smaller override is illegal.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- y1_re, y1_im, y2_re, y2_im  in  DIN_WIDTH each, signed  transformed sample pair.
- din_valid  in  1  sample qualifier; may have arbitrary gaps.
- acc_len  in  ACC_LEN_WIDTH  samples per window; 0 treated as 1.
- r11, r22, r12  out  DOUT_WIDTH each, signed  integrated correlation entries.
- dout_valid  out  1  one-cycle pulse; outputs are valid while high.
- win_cnt  out  16  count of windows emitted since reset, wraps at 2^16.

Behaviour:
- Reset (async assert, sync release) clears: all pipeline registers, valid/first/last tags, sample counter, accumulators, r11/r22/r12 = 0, dout_valid = 0, win_cnt = 0.
- Pipeline: E0 registers inputs, valid and tags. E1 computes six products. E2 forms the sums. E3 accumulates and produces output.
- The pipeline advances every clock. Each stage carries its own valid bit; a stage-3 accumulator update happens only when its valid bit is high.
- Stage E2 sums (each 2*DIN_WIDTH+1 bits, signed):
  - s11 = y1_re^2 + y1_im^2
  - s22 = y2_re^2 + y2_im^2
  - s12 = y1_re*y2_re + y1_im*y2_im
- Sign-extend each sum to DOUT_WIDTH before accumulating.
- Sample counter (input stage):
  - Increments on each valid sample.
  - Flags the first sample of a window (count == 0).
  - Flags the last sample when count == eff_len - 1, then returns to 0.
- eff_len is latched from acc_len (0 -> 1) when the first sample of a window is accepted. acc_len changes mid-window take effect from the next window.
- Tagged first sample: the accumulator loads the sum rather than adding to it, so consecutive windows run back-to-back with no bubble. A window of length 1 is both first and last.
- Tagged last sample:
  - r11/r22/r12 <= accumulated value including that sample.
  - dout_valid = 1 for exactly one cycle, the cycle after edge E0+3, where E0 is the edge that samples the last din_valid.
  - win_cnt increments on the same edge.
  - Outputs hold their values until the next window completes.
- Latency is fixed at 4 edges regardless of din_valid gaps; gaps only stretch the window.
- r11 and r22 are always >= 0; r12 may be negative.
- Width rule guarantees no overflow at full scale, e.g. (-2^18)^2 * 2 * 1023 fits.
- Reset mid-window discards the partial window. The first valid sample after release starts a new window; no stale dout_valid is produced.
- din_valid low on the cycle that would complete a window: nothing is emitted until the last sample actually arrives.

Decomposition:
- Shared package `doa_pkg`:
  - DIN_WIDTH and ACC_LEN_WIDTH defaults.
  - Derived DOUT_WIDTH function.
  - Pipeline latency constant CORR_LAT = 4, used by downstream alignment and the bench.
- Natural sub-module `corr_mac`: two signed multiplies, an add, and an accumulator with load/add/emit controls, valid tag in/out.
- Instantiate corr_mac three times (r11, r22, r12). Counter and window control stay in the top level.

Test Plan:
1. acc_len=1; y1=(3,4), y2=(1,-2) -> after 4 edges r11=25, r22=5, r12=-5, dout_valid one cycle, win_cnt=1.
2. acc_len=4; constant y1=(1,1), y2=(2,0), din_valid 1-0-1-1-0-1 -> one pulse only after the 4th valid sample: r11=8, r22=16, r12=8.
3. Full scale: acc_len=1023; all components -2^18 every cycle -> r11 = r22 = r12 = 2*2^36*1023 exactly, no wrap; then y2 = +(2^18-1) -> r12 negative and exact.
4. Back-to-back windows with acc_len=2 and continuous valid, values ramping 1..6 on y1_re only, other components 0 -> three pulses two cycles apart: r11 = 5, 25, 61.
5. acc_len changed from 4 to 2 after the 2nd sample of a window -> current window still closes after 4 samples; the next window closes after 2.
6. rst_n pulsed low after 3 of 4 samples -> all outputs 0 immediately (async), no pulse. The first window after release is exactly 4 fresh samples with correct sums; win_cnt restarts at 1.

Source files
------------

// File: rtl/doa_pkg.sv
// -----------------------------------------------------------------------------
// doa_pkg
// Shared definitions for the DoA front end: default widths of the transformed
// samples and of the window length, the accumulator width rule, the fixed
// correlation latency that downstream alignment relies on, and the tag bundle
// that travels alongside each sample through the correlation pipeline.
// -----------------------------------------------------------------------------
package doa_pkg;

    // Signed width of each transformed y component (transform width + 1).
    localparam int DIN_WIDTH_DEF     = 32'd19;
    // Width of the runtime window length; longest window is 2^W - 1 samples.
    localparam int ACC_LEN_WIDTH_DEF = 32'd10;
    // Edges from the sampling of the last din_valid to the output update.
    localparam int CORR_LAT          = 32'd4;

    // Accumulator width that can never overflow: a sum of two full-scale
    // squares needs 2*din_w+1 bits, and up to 2^acc_w - 1 of them are added.
    function automatic int corr_dout_width(input int din_w, input int acc_w);
        return (32'd2 * din_w) + 32'd1 + acc_w;
    endfunction

    // Per-sample qualifiers carried in lock-step with the data.
    typedef struct packed {
        logic valid;  // sample present in this stage
        logic first;  // first sample of a window: accumulator loads
        logic last;   // last sample of a window: result is emitted
    } corr_tag_t;

endpackage

// File: rtl/corr_mac.sv
// -----------------------------------------------------------------------------
// corr_mac
// One correlation lane: acc_out accumulates a0*b0 + a1*b1 over a window.
//   Stage E1: two signed products (registered).
//   Stage E2: their sum, 2*DIN_WIDTH+1 bits (registered).
//   Stage E3: sign-extended sum is loaded into or added to the accumulator;
//             on an emit the updated value is copied to acc_out.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   a0, b0, a1, b1        signed operands, already registered by the caller
//   acc_valid/load/emit   stage-2 aligned controls for the accumulator stage
//   acc_out               window result, held until the next emit
//   out_valid             one-cycle pulse when acc_out has just been updated
// -----------------------------------------------------------------------------
module corr_mac
    import doa_pkg::*;
#(
    parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
    parameter int DOUT_WIDTH = corr_dout_width(DIN_WIDTH_DEF, ACC_LEN_WIDTH_DEF)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DIN_WIDTH-1:0]  a0,
    input  logic signed [DIN_WIDTH-1:0]  b0,
    input  logic signed [DIN_WIDTH-1:0]  a1,
    input  logic signed [DIN_WIDTH-1:0]  b1,
    input  logic                         acc_valid,
    input  logic                         acc_load,
    input  logic                         acc_emit,
    output logic signed [DOUT_WIDTH-1:0] acc_out,
    output logic                         out_valid
);

    localparam int PROD_W = 2 * DIN_WIDTH;
    localparam int SUM_W  = PROD_W + 1;

    logic signed [PROD_W-1:0]     p0_r;
    logic signed [PROD_W-1:0]     p1_r;
    logic signed [SUM_W-1:0]      sum_r;
    logic signed [DOUT_WIDTH-1:0] acc_r;
    logic signed [DOUT_WIDTH-1:0] sum_ext_s;
    logic signed [DOUT_WIDTH-1:0] acc_next_s;

    // Next accumulator value: a first sample restarts the window with no bubble.
    always_comb begin
        sum_ext_s = {{(DOUT_WIDTH - SUM_W){sum_r[SUM_W-1]}}, sum_r};
        if (acc_load) begin
            acc_next_s = sum_ext_s;
        end else begin
            acc_next_s = acc_r + sum_ext_s;
        end
    end

    // E1: full-precision products; operands widened first so no bits are lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_r <= {PROD_W{1'b0}};
            p1_r <= {PROD_W{1'b0}};
        end else begin
            p0_r <= PROD_W'(a0) * PROD_W'(b0);
            p1_r <= PROD_W'(a1) * PROD_W'(b1);
        end
    end

    // E2: sum of the two products with one guard bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= {SUM_W{1'b0}};
        end else begin
            sum_r <= SUM_W'(p0_r) + SUM_W'(p1_r);
        end
    end

    // E3: accumulate qualified samples and publish the result at window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= {DOUT_WIDTH{1'b0}};
            acc_out   <= {DOUT_WIDTH{1'b0}};
            out_valid <= 1'b0;
        end else begin
            if (acc_valid) begin
                acc_r <= acc_next_s;
                if (acc_emit) begin
                    acc_out <= acc_next_s;
                end
            end
            out_valid <= acc_valid & acc_emit;
        end
    end

endmodule

// File: rtl/real_corr_acc.sv
// -----------------------------------------------------------------------------
// real_corr_acc
// Integrates the real 2x2 correlation matrix Re{y y^H} of the transformed pair
// (y1, y2) over a runtime-selectable window and emits r11, r22 and r12 once per
// window. Fixed 4-edge latency from the last accepted sample to the output;
// gaps in din_valid only stretch the window. Full precision, no saturation.
// DOUT_WIDTH must not be overridden below corr_dout_width(DIN, ACC_LEN).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   y1_re, y1_im, y2_re, y2_im  signed transformed sample pair
//   din_valid                   sample qualifier, arbitrary gaps allowed
//   acc_len                     samples per window (0 behaves as 1)
//   r11, r22, r12               window results, held until the next window
//   dout_valid                  one-cycle pulse when the results update
//   win_cnt                     windows emitted since reset, wraps at 2^16
// -----------------------------------------------------------------------------
module real_corr_acc
    import doa_pkg::*;
#(
    parameter int DIN_WIDTH     = DIN_WIDTH_DEF,
    parameter int ACC_LEN_WIDTH = ACC_LEN_WIDTH_DEF,
    parameter int DOUT_WIDTH    = corr_dout_width(DIN_WIDTH, ACC_LEN_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DIN_WIDTH-1:0]  y1_re,
    input  logic signed [DIN_WIDTH-1:0]  y1_im,
    input  logic signed [DIN_WIDTH-1:0]  y2_re,
    input  logic signed [DIN_WIDTH-1:0]  y2_im,
    input  logic                         din_valid,
    input  logic [ACC_LEN_WIDTH-1:0]     acc_len,
    output logic signed [DOUT_WIDTH-1:0] r11,
    output logic signed [DOUT_WIDTH-1:0] r22,
    output logic signed [DOUT_WIDTH-1:0] r12,
    output logic                         dout_valid,
    output logic [15:0]                  win_cnt
);

    localparam logic [ACC_LEN_WIDTH-1:0] CNT_ZERO = {ACC_LEN_WIDTH{1'b0}};
    localparam logic [ACC_LEN_WIDTH-1:0] CNT_ONE  = {{(ACC_LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [ACC_LEN_WIDTH-1:0] cnt_r;
    logic [ACC_LEN_WIDTH-1:0] eff_len_r;
    logic [ACC_LEN_WIDTH-1:0] len_in_s;
    logic [ACC_LEN_WIDTH-1:0] len_now_s;
    logic                     first_s;
    logic                     last_s;

    logic signed [DIN_WIDTH-1:0] y1_re_r;
    logic signed [DIN_WIDTH-1:0] y1_im_r;
    logic signed [DIN_WIDTH-1:0] y2_re_r;
    logic signed [DIN_WIDTH-1:0] y2_im_r;

    corr_tag_t e0_tag_r;
    corr_tag_t e1_tag_r;
    corr_tag_t e2_tag_r;

    logic v11_s;
    logic v22_s;
    logic v12_s;

    // Window position of the incoming sample; a new window uses the current
    // acc_len, an open window keeps the length latched at its first sample.
    always_comb begin
        first_s = (cnt_r == CNT_ZERO);
        if (acc_len == CNT_ZERO) begin
            len_in_s = CNT_ONE;
        end else begin
            len_in_s = acc_len;
        end
        if (first_s) begin
            len_now_s = len_in_s;
        end else begin
            len_now_s = eff_len_r;
        end
        last_s = (cnt_r == (len_now_s - CNT_ONE));
    end

    // Sample counter and per-window length latch, advanced only by valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= CNT_ZERO;
            eff_len_r <= CNT_ONE;
        end else if (din_valid) begin
            if (first_s) begin
                eff_len_r <= len_in_s;
            end
            if (last_s) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // E0: register the sample pair together with its window tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1_re_r  <= {DIN_WIDTH{1'b0}};
            y1_im_r  <= {DIN_WIDTH{1'b0}};
            y2_re_r  <= {DIN_WIDTH{1'b0}};
            y2_im_r  <= {DIN_WIDTH{1'b0}};
            e0_tag_r <= '{valid: 1'b0, first: 1'b0, last: 1'b0};
        end else begin
            y1_re_r        <= y1_re;
            y1_im_r        <= y1_im;
            y2_re_r        <= y2_re;
            y2_im_r        <= y2_im;
            e0_tag_r.valid <= din_valid;
            e0_tag_r.first <= din_valid & first_s;
            e0_tag_r.last  <= din_valid & last_s;
        end
    end

    // E1/E2: tags follow the product and sum stages inside the MAC lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_tag_r <= '{valid: 1'b0, first: 1'b0, last: 1'b0};
            e2_tag_r <= '{valid: 1'b0, first: 1'b0, last: 1'b0};
        end else begin
            e1_tag_r <= e0_tag_r;
            e2_tag_r <= e1_tag_r;
        end
    end

    // Window counter steps on the same edge that publishes the results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= 16'd0;
        end else if (e2_tag_r.valid & e2_tag_r.last) begin
            win_cnt <= win_cnt + 16'd1;
        end
    end

    // r11 = y1_re^2 + y1_im^2
    corr_mac #(.DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)) u_mac_11 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a0        (y1_re_r),
        .b0        (y1_re_r),
        .a1        (y1_im_r),
        .b1        (y1_im_r),
        .acc_valid (e2_tag_r.valid),
        .acc_load  (e2_tag_r.first),
        .acc_emit  (e2_tag_r.last),
        .acc_out   (r11),
        .out_valid (v11_s)
    );

    // r22 = y2_re^2 + y2_im^2
    corr_mac #(.DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)) u_mac_22 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a0        (y2_re_r),
        .b0        (y2_re_r),
        .a1        (y2_im_r),
        .b1        (y2_im_r),
        .acc_valid (e2_tag_r.valid),
        .acc_load  (e2_tag_r.first),
        .acc_emit  (e2_tag_r.last),
        .acc_out   (r22),
        .out_valid (v22_s)
    );

    // r12 = y1_re*y2_re + y1_im*y2_im (real part of y1*conj(y2))
    corr_mac #(.DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)) u_mac_12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a0        (y1_re_r),
        .b0        (y2_re_r),
        .a1        (y1_im_r),
        .b1        (y2_im_r),
        .acc_valid (e2_tag_r.valid),
        .acc_load  (e2_tag_r.first),
        .acc_emit  (e2_tag_r.last),
        .acc_out   (r12),
        .out_valid (v12_s)
    );

    // All three lanes share one tag stream, so their pulses coincide.
    assign dout_valid = v11_s & v22_s & v12_s;

endmodule

// File: tb/tb_real_corr_acc.sv
// -----------------------------------------------------------------------------
// tb_real_corr_acc
// Directed bench for real_corr_acc: every dout_valid pulse is captured with its
// results, win_cnt and cycle stamp, then compared against hand-derived values.
// -----------------------------------------------------------------------------
module tb_real_corr_acc;
    import doa_pkg::*;

    localparam int DW = 19;
    localparam int AW = 10;
    localparam int OW = 49;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] y1_re, y1_im, y2_re, y2_im;
    logic                 din_valid;
    logic [AW-1:0]        acc_len;
    logic signed [OW-1:0] r11, r22, r12;
    logic                 dout_valid;
    logic [15:0]          win_cnt;

    real_corr_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .y1_re      (y1_re),
        .y1_im      (y1_im),
        .y2_re      (y2_re),
        .y2_im      (y2_im),
        .din_valid  (din_valid),
        .acc_len    (acc_len),
        .r11        (r11),
        .r22        (r22),
        .r12        (r12),
        .dout_valid (dout_valid),
        .win_cnt    (win_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint r11;
        longint r22;
        longint r12;
        longint wc;
        int     cyc;
    } pulse_t;
    pulse_t pq[$];

    always @(negedge clk) begin
        if (dout_valid !== 1'b0) begin
            pq.push_back('{longint'(r11), longint'(r22), longint'(r12),
                           longint'(win_cnt), cyc});
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int last_cyc = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int a, input int b, input int c, input int d, input logic v);
        @(negedge clk);
        y1_re     = DW'(a);
        y1_im     = DW'(b);
        y2_re     = DW'(c);
        y2_im     = DW'(d);
        din_valid = v;
        last_cyc  = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    task automatic chk_pulse(input string tag, input int idx, input longint e11,
                             input longint e22, input longint e12,
                             input longint ewc, input int ecyc);
        if (idx < pq.size()) begin
            chk({tag, "_r11"}, pq[idx].r11, e11);
            chk({tag, "_r22"}, pq[idx].r22, e22);
            chk({tag, "_r12"}, pq[idx].r12, e12);
            chk({tag, "_win_cnt"}, pq[idx].wc, ewc);
            chk({tag, "_latency"}, longint'(pq[idx].cyc), longint'(ecyc));
        end else begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: pulse %0d missing, observed %0d pulses", tag, idx, pq.size());
        end
    endtask

    initial begin
        int c0, c1, c2;
        longint m, p, full, r22b, r12b;

        rst_n     = 1'b1;
        y1_re     = '0;
        y1_im     = '0;
        y2_re     = '0;
        y2_im     = '0;
        din_valid = 1'b0;
        acc_len   = AW'(1);
        #2 rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_r11", longint'(r11), 64'sd0);
        chk("rst_r22", longint'(r22), 64'sd0);
        chk("rst_r12", longint'(r12), 64'sd0);
        chk("rst_dout_valid", longint'(dout_valid), 64'sd0);
        chk("rst_win_cnt", longint'(win_cnt), 64'sd0);
        rst_n = 1'b1;

        // 1: single-sample window
        acc_len = AW'(1);
        drive(3, 4, 1, -2, 1'b1);
        c0 = last_cyc;
        idle(8);
        chk("t1_pulses", longint'(pq.size()), 64'sd1);
        chk_pulse("t1", 0, 64'sd25, 64'sd5, -64'sd5, 64'sd1, c0 + CORR_LAT);
        pq.delete();

        // 2: window of 4 with gaps in din_valid
        acc_len = AW'(4);
        drive(1, 1, 2, 0, 1'b1);
        drive(1, 1, 2, 0, 1'b0);
        drive(1, 1, 2, 0, 1'b1);
        drive(1, 1, 2, 0, 1'b1);
        drive(1, 1, 2, 0, 1'b0);
        drive(1, 1, 2, 0, 1'b1);
        c0 = last_cyc;
        idle(8);
        chk("t2_pulses", longint'(pq.size()), 64'sd1);
        chk_pulse("t2", 0, 64'sd8, 64'sd16, 64'sd8, 64'sd2, c0 + CORR_LAT);
        pq.delete();

        // 3: full-scale windows of 1023 samples
        m = 64'sd262144;
        p = 64'sd262143;
        full = 64'sd1023 * 64'sd2 * m * m;
        r22b = 64'sd1023 * 64'sd2 * p * p;
        r12b = -(64'sd1023 * 64'sd2 * m * p);
        acc_len = AW'(1023);
        for (int i = 0; i < 1023; i++) drive(-262144, -262144, -262144, -262144, 1'b1);
        c0 = last_cyc;
        for (int i = 0; i < 1023; i++) drive(-262144, -262144, 262143, 262143, 1'b1);
        c1 = last_cyc;
        idle(8);
        chk("t3_pulses", longint'(pq.size()), 64'sd2);
        chk_pulse("t3a", 0, full, full, full, 64'sd3, c0 + CORR_LAT);
        chk_pulse("t3b", 1, full, r22b, r12b, 64'sd4, c1 + CORR_LAT);
        pq.delete();

        // 4: back-to-back windows of 2, ramp on y1_re
        acc_len = AW'(2);
        drive(1, 0, 0, 0, 1'b1);
        drive(2, 0, 0, 0, 1'b1);
        c0 = last_cyc;
        drive(3, 0, 0, 0, 1'b1);
        drive(4, 0, 0, 0, 1'b1);
        c1 = last_cyc;
        drive(5, 0, 0, 0, 1'b1);
        drive(6, 0, 0, 0, 1'b1);
        c2 = last_cyc;
        idle(8);
        chk("t4_pulses", longint'(pq.size()), 64'sd3);
        chk_pulse("t4a", 0, 64'sd5, 64'sd0, 64'sd0, 64'sd5, c0 + CORR_LAT);
        chk_pulse("t4b", 1, 64'sd25, 64'sd0, 64'sd0, 64'sd6, c1 + CORR_LAT);
        chk_pulse("t4c", 2, 64'sd61, 64'sd0, 64'sd0, 64'sd7, c2 + CORR_LAT);
        pq.delete();

        // 5: acc_len 4 -> 2 after the 2nd sample of a window
        acc_len = AW'(4);
        drive(1, 0, 0, 0, 1'b1);
        drive(1, 0, 0, 0, 1'b1);
        acc_len = AW'(2);
        drive(1, 0, 0, 0, 1'b1);
        drive(1, 0, 0, 0, 1'b1);
        c0 = last_cyc;
        drive(1, 0, 0, 0, 1'b1);
        drive(1, 0, 0, 0, 1'b1);
        c1 = last_cyc;
        idle(8);
        chk("t5_pulses", longint'(pq.size()), 64'sd2);
        chk_pulse("t5a", 0, 64'sd4, 64'sd0, 64'sd0, 64'sd8, c0 + CORR_LAT);
        chk_pulse("t5b", 1, 64'sd2, 64'sd0, 64'sd0, 64'sd9, c1 + CORR_LAT);
        pq.delete();

        // 6: asynchronous reset after 3 of 4 samples
        acc_len = AW'(4);
        drive(1, 0, 0, 0, 1'b1);
        drive(1, 0, 0, 0, 1'b1);
        drive(1, 0, 0, 0, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_r11", longint'(r11), 64'sd0);
        chk("t6_rst_r22", longint'(r22), 64'sd0);
        chk("t6_rst_r12", longint'(r12), 64'sd0);
        chk("t6_rst_dout_valid", longint'(dout_valid), 64'sd0);
        chk("t6_rst_win_cnt", longint'(win_cnt), 64'sd0);
        pq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        chk("t6_no_stale_pulse", longint'(pq.size()), 64'sd0);
        drive(2, 1, 1, 1, 1'b1);
        drive(2, 1, 1, 1, 1'b1);
        drive(2, 1, 1, 1, 1'b1);
        drive(2, 1, 1, 1, 1'b1);
        c0 = last_cyc;
        idle(8);
        chk("t6_pulses", longint'(pq.size()), 64'sd1);
        chk_pulse("t6", 0, 64'sd20, 64'sd8, 64'sd12, 64'sd1, c0 + CORR_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
